cnna_acc_requant: RTL and testbench
===================================

# cnna_acc_requant

Accumulate-and-requantize stage directly downstream of the 16s×13ns scale multiplier in the CNN datapath. Consumes a stream of signed 16-bit scaled products, sums a programmable-length group onto a bias, and applies arithmetic right shift with round-half-up, optional ReLU and saturation. It emits one signed 8-bit activation per group over a valid/ready handshake.

## Interface
- IN_W, 16, product width (signed)
- ACC_W, 32, accumulator width (signed)
- OUT_W, 8, output activation width (signed)
- CNT_W, 10, group-length counter width
- ap_clk  in  1  clock; one clock domain, all logic on the rising edge
- ap_rst  in  1  reset; synchronous, active-high
- cfg_len  in  CNT_W  products per group; 0 is treated as 1
- cfg_shift  in  4  right-shift amount, 0..15
- cfg_bias  in  16  signed bias; initial accumulator value
- cfg_relu  in  1  1 = clamp negative results to 0
- in_data  in  IN_W  signed product from the multiplier
- in_valid  in  1  in_data valid
- in_ready  out  1  stage accepts in_data this cycle
- out_data  out  OUT_W  requantized signed result
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- sat_pulse  out  1  one-cycle pulse: saturation occurred on the result just loaded

## Operation
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- States: IDLE, ACC, FIN, OUT.
- IDLE:
  - in_ready=1.
  - On the first input transfer, latch cfg_len/shift/bias/relu into shadow registers.
  - Set acc = sext(cfg_bias) + sext(in_data) and cnt = 1.
  - If the latched len ≤ 1, go to FIN; otherwise go to ACC.
- ACC:
  - in_ready=1.
  - On each transfer, acc += sext(in_data) and cnt++.
  - The transfer that makes cnt == len moves the FSM to FIN.
  - Cycles without in_valid leave acc and cnt unchanged.
- FIN:
  - in_ready=0.
  - Compute r = shift==0 ? acc : (acc + (1<<(shift-1))) >>> shift.
  - If relu && r<0, r = 0.
  - Saturate r to [-128, 127].
  - Register the result into out_data, set out_valid=1, pulse sat_pulse if clipping occurred, go to OUT.
- OUT:
  - in_ready=0.
  - out_data is held stable while out_valid && !out_ready.
  - On an output transfer, out_valid=0 and the FSM goes to IDLE.
- Config inputs are ignored outside the IDLE first-transfer cycle.
- Overflow: ACC_W=32 is sufficient for 1023 × 2^15 plus bias, so no accumulator wrap is possible at the default parameters.
- Reset (also mid-group or mid-OUT):
  - state=IDLE, acc=0, cnt=0, shadow config=0.
  - out_valid=0, out_data=0, sat_pulse=0.
  - The partial group is discarded with no output.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 on the first cycle after it. out_valid=0, out_data=0, sat_pulse=0.
- Latency: last product accepted at cycle t; FIN at t+1; out_valid=1 at t+2.
- Minimum group period is len+2 cycles when out_ready is held at 1.
- in_ready is combinational from state only. It never depends on in_valid or out_ready.
- sat_pulse is asserted in the same cycle that out_valid first rises. It lasts exactly one cycle even under backpressure.

## Structure
- Shared package cnna_acc_pkg:
  - FSM state enum.
  - Saturation bounds SAT_MAX=127, SAT_MIN=-128.
  - Shift-field width constant (4).
- One sub-module, cnna_requant_rnd: a combinational round/ReLU/saturate function from ACC_W to OUT_W plus a sat flag, instantiated in FIN.

## Test plan
- len=4, bias=0, shift=2, relu=0, inputs 10,20,30,40 -> out_data=25, out_valid 2 cycles after the 4th accept, sat_pulse=0.
- len=1, bias=0, shift=1, input -5 -> out_data=-2 (round-half-up toward +inf).
- len=2, shift=0, inputs 32767,32767 -> out_data=127, sat_pulse=1; repeat with relu=1 and inputs -300,-1 -> out_data=0, sat_pulse=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout; accept resumes the cycle after the output transfer.
- Gapped input: len=3, bias=7, inputs 1,2,3 with in_valid low 2 cycles between each -> out_data=13 (shift=0).
- ap_rst asserted after 2 of 4 products -> no output. The next group (len=1, bias=0, shift=0, input 9) -> out_data=9.

Source files
------------

// File: rtl/cnna_acc_pkg.sv
// Shared types and constants for the accumulate-and-requantize stage.
package cnna_acc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StFin,
        StOut
    } acc_state_e;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned BIAS_W  = 16;

endpackage

// File: rtl/cnna_requant_rnd.sv
// Combinational requantizer: round-half-up arithmetic right shift, optional ReLU,
// saturation to the signed output range with a clip flag.
module cnna_requant_rnd
    import cnna_acc_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 8
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu,
    output logic [OUT_W-1:0]   res,
    output logic               sat
);

    // One guard bit so adding the rounding half never wraps.
    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] rnd;

    always_comb begin
        acc_ext = $signed({acc[ACC_W-1], acc});
        half    = '0;
        if (shift == '0) begin
            rnd = acc_ext;
        end else begin
            half[shift - 4'd1] = 1'b1;
            rnd = (acc_ext + half) >>> shift;
        end

        sat = 1'b0;
        res = rnd[OUT_W-1:0];
        if (relu && rnd < 0) begin
            res = '0;
        end else if (rnd > SAT_MAX) begin
            res = OUT_W'(SAT_MAX);
            sat = 1'b1;
        end else if (rnd < SAT_MIN) begin
            res = OUT_W'(SAT_MIN);
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/cnna_acc_requant.sv
// Sums a programmable-length group of signed products onto a bias and emits one
// requantized signed activation per group over a valid/ready handshake.
module cnna_acc_requant
    import cnna_acc_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 10
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [CNT_W-1:0]   cfg_len,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [BIAS_W-1:0]  cfg_bias,
    input  logic               cfg_relu,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sat_pulse
);

    acc_state_e         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [BIAS_W-1:0]  bias_q, bias_d;
    logic               relu_q, relu_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               sat_q, sat_d;

    logic               in_xfer;
    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W-1:0]   bias_ext;
    logic [OUT_W-1:0]   rnd_res;
    logic               rnd_sat;

    assign in_ready = !ap_rst && (state_q == StIdle || state_q == StAcc);
    assign in_xfer  = in_valid && in_ready;
    assign in_ext   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign bias_ext = {{(ACC_W-BIAS_W){cfg_bias[BIAS_W-1]}}, cfg_bias};

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sat_pulse = sat_q;

    cnna_requant_rnd #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_rnd (
        .acc   (acc_q),
        .shift (shift_q),
        .relu  (relu_q),
        .res   (rnd_res),
        .sat   (rnd_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        shift_d     = shift_q;
        bias_d      = bias_q;
        relu_d      = relu_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_xfer) begin
                    len_d   = cfg_len;
                    shift_d = cfg_shift;
                    bias_d  = cfg_bias;
                    relu_d  = cfg_relu;
                    acc_d   = bias_ext + in_ext;
                    cnt_d   = CNT_W'(1);
                    // A length of 0 behaves as 1: the group is already complete.
                    state_d = (cfg_len <= CNT_W'(1)) ? StFin : StAcc;
                end
            end
            StAcc: begin
                if (in_xfer) begin
                    acc_d = acc_q + in_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                out_data_d  = rnd_res;
                out_valid_d = 1'b1;
                sat_d       = rnd_sat;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_cnna_acc_requant.sv
// Scoreboard bench for cnna_acc_requant: directed cases plus randomized groups
// checked against an arithmetic reference model.
module tb_cnna_acc_requant;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [9:0]  cfg_len;
    logic [3:0]  cfg_shift;
    logic [15:0] cfg_bias;
    logic        cfg_relu;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int out_mode = 0;   // 0: always ready, 1: random ready, 2: stalled
    bit done     = 0;

    int exp_data[$];
    bit exp_sat[$];

    cnna_acc_requant dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .cfg_bias  (cfg_bias),
        .cfg_relu  (cfg_relu),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_pulse (sat_pulse)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: exact integer sum, floor((sum + 2^(s-1)) / 2^s), then ReLU and clamp.
    function automatic void model(input int shift, input int bias, input int relu,
                                  input int vals[$], output int res, output bit sat);
        longint s = bias;
        longint r;
        foreach (vals[i]) s += vals[i];
        r = s;
        if (shift > 0) begin
            longint d = longint'(1) << shift;
            longint n = s + d / 2;
            r = n / d;
            if ((n % d != 0) && n < 0) r = r - 1;
        end
        sat = 1'b0;
        if (relu != 0 && r < 0) r = 0;
        else if (r > 127) begin r = 127; sat = 1'b1; end
        else if (r < -128) begin r = -128; sat = 1'b1; end
        res = int'(r);
    endfunction

    always begin
        @(posedge ap_clk);
        #1;
        if (out_mode == 0) out_ready = 1'b1;
        else if (out_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b0;
    end

    // Monitor: pops an expectation on each newly presented output.
    initial begin
        bit prev_valid = 0;
        int held = 0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                prev_valid = 0;
            end else if (out_valid) begin
                check("in_ready_low_in_out", int'(in_ready), 0);
                if (!prev_valid) begin
                    if (exp_data.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got %0d, expected none",
                                 $signed(out_data));
                    end else begin
                        check("out_data", longint'($signed(out_data)), exp_data.pop_front());
                        check("sat_pulse", int'(sat_pulse), int'(exp_sat.pop_front()));
                    end
                    held = int'($signed(out_data));
                end else begin
                    check("out_data_stable", longint'($signed(out_data)), held);
                    check("sat_pulse_one_cycle", int'(sat_pulse), 0);
                end
                prev_valid = 1;
            end else begin
                prev_valid = 0;
            end
        end
    end

    task automatic wait_accept();
        bit got = 0;
        int budget = 0;
        while (!got && budget < 2000) begin
            @(negedge ap_clk);
            got = in_ready;
            @(posedge ap_clk);
            #1;
            budget++;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL accept_timeout: got no in_ready, expected in_ready within 2000 cycles");
        end
    endtask

    task automatic send_group(input int len, input int shift, input int bias, input int relu,
                              input int vals[$], input int gap);
        int n = (len == 0) ? 1 : len;
        int r;
        bit s;
        model(shift, bias, relu, vals, r, s);
        cfg_len   = 10'(len);
        cfg_shift = 4'(shift);
        cfg_bias  = 16'(bias);
        cfg_relu  = 1'(relu);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(vals[i]);
            wait_accept();
            in_valid = 1'b0;
            if (i == 0) begin
                // Shadowed config must ignore later changes.
                cfg_len   = 10'($urandom);
                cfg_shift = 4'($urandom);
                cfg_bias  = 16'($urandom);
                cfg_relu  = 1'($urandom);
            end
            if (i == n - 1) begin
                exp_data.push_back(r);
                exp_sat.push_back(s);
            end else begin
                repeat (gap) begin
                    @(posedge ap_clk);
                    #1;
                end
            end
        end
        @(negedge ap_clk);
        check("latency_fin", int'(out_valid), 0);
        @(negedge ap_clk);
        check("latency_out", int'(out_valid), 1);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        int vals[$];
        ap_rst    = 1'b1;
        cfg_len   = '0;
        cfg_shift = '0;
        cfg_bias  = '0;
        cfg_relu  = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_sat_pulse", int'(sat_pulse), 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        @(posedge ap_clk);
        #1;

        vals = '{10, 20, 30, 40};     send_group(4, 2, 0, 0, vals, 0);
        vals = '{-5};                 send_group(1, 1, 0, 0, vals, 0);
        vals = '{32767, 32767};       send_group(2, 0, 0, 0, vals, 0);
        vals = '{-300, -1};           send_group(2, 0, 0, 1, vals, 0);
        vals = '{1, 2, 3};            send_group(3, 0, 7, 0, vals, 2);
        vals = '{50};                 send_group(0, 0, 0, 0, vals, 0);
        vals = '{-129};               send_group(1, 0, 0, 0, vals, 0);
        vals = '{-3};                 send_group(1, 1, 0, 0, vals, 0);

        // Backpressure: stalled for several cycles after out_valid rises.
        out_mode = 2;
        @(posedge ap_clk);
        #1;
        vals = '{100, -20};
        send_group(2, 1, 5, 0, vals, 0);
        repeat (4) begin
            @(negedge ap_clk);
            check("bp_in_ready", int'(in_ready), 0);
        end
        out_mode = 0;
        @(posedge ap_clk);
        #3;
        @(negedge ap_clk);
        check("bp_transfer_valid", int'(out_valid & out_ready), 1);
        @(negedge ap_clk);
        check("bp_resume_in_ready", int'(in_ready), 1);
        check("bp_out_valid_clear", int'(out_valid), 0);
        @(posedge ap_clk);
        #1;

        // Reset mid-group discards the partial sum.
        cfg_len   = 10'd4;
        cfg_shift = 4'd0;
        cfg_bias  = 16'd0;
        cfg_relu  = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd5;
        wait_accept();
        in_data   = 16'd6;
        wait_accept();
        in_valid  = 1'b0;
        ap_rst    = 1'b1;
        @(negedge ap_clk);
        check("midrst_in_ready", int'(in_ready), 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("midrst_in_ready_after", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        @(posedge ap_clk);
        #1;
        vals = '{9};
        send_group(1, 0, 0, 0, vals, 0);

        // Longest group at extreme values.
        vals.delete();
        for (int i = 0; i < 1023; i++) vals.push_back(-32768);
        send_group(1023, 15, -32768, 0, vals, 0);

        // Randomized groups with random backpressure.
        out_mode = 1;
        for (int g = 0; g < 60; g++) begin
            int len = $urandom_range(0, 8);
            int n = (len == 0) ? 1 : len;
            int sh = $urandom_range(0, 4);
            vals.delete();
            for (int i = 0; i < n; i++)
                vals.push_back(int'($signed(16'($urandom))) >>> $urandom_range(4, 12));
            send_group(len, sh, int'($signed(16'($urandom))) >>> $urandom_range(6, 15),
                       $urandom_range(0, 1), vals, $urandom_range(0, 2));
        end

        out_mode = 0;
        begin
            int budget = 0;
            while (exp_data.size() != 0 && budget < 200) begin
                @(posedge ap_clk);
                budget++;
            end
            if (exp_data.size() != 0) begin
                n_checks++;
                $display("FAIL drain: got %0d pending outputs, expected 0", exp_data.size());
            end
        end
        repeat (3) @(posedge ap_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        done = 1;
        $finish;
    end

endmodule
